// File: rtl/controlador_copia_memoria.sv
// controlador_copia_memoria
// Bus initiator for the 256x8 synchronous data memory (memoria_dados).
// Performs either a forward block copy (origem -> destino, tamanho bytes)
// or a block fill (valor written to tamanho bytes starting at destino).
//
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   inicio           start request, sampled only while idle
//   modo             0 = copy, 1 = fill
//   origem           copy source start address
//   destino          destination start address
//   tamanho          byte count (0 = no transfer, just completes)
//   valor            fill byte
//   ocupado          high while the controller owns the memory port
//   concluido        one-cycle completion pulse
//   mem_writeEnable  memory write strobe
//   mem_endereco     memory address
//   mem_dadoEntrada  memory write data
//   mem_dadoSaida    memory read data, valid the cycle after its address

module controlador_copia_memoria #(
  parameter int LARG_END  = 8,
  parameter int LARG_DADO = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inicio,
  input  logic                 modo,
  input  logic [LARG_END-1:0]  origem,
  input  logic [LARG_END-1:0]  destino,
  input  logic [LARG_END-1:0]  tamanho,
  input  logic [LARG_DADO-1:0] valor,
  output logic                 ocupado,
  output logic                 concluido,
  output logic                 mem_writeEnable,
  output logic [LARG_END-1:0]  mem_endereco,
  output logic [LARG_DADO-1:0] mem_dadoEntrada,
  input  logic [LARG_DADO-1:0] mem_dadoSaida
);

  localparam logic [LARG_END-1:0] UM = LARG_END'(1);

  typedef enum logic [2:0] {
    OCIOSO,
    LE,
    ESCREVE,
    PREENCHE,
    FIM
  } estado_t;

  estado_t estado, prox_estado;

  logic [LARG_END-1:0]  ptr_o;
  logic [LARG_END-1:0]  ptr_d;
  logic [LARG_END-1:0]  cont;
  logic [LARG_DADO-1:0] reg_valor;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado <= OCIOSO;
    end else begin
      estado <= prox_estado;
    end
  end

  // Pointers, byte counter and fill byte. Parameters are captured only on
  // the accepting edge, so later input changes cannot disturb a transfer.
  // Pointer increments wrap naturally at the address width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_o     <= '0;
      ptr_d     <= '0;
      cont      <= '0;
      reg_valor <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (inicio) begin
            ptr_o     <= origem;
            ptr_d     <= destino;
            cont      <= tamanho;
            reg_valor <= valor;
          end
        end
        ESCREVE: begin
          ptr_o <= ptr_o + UM;
          ptr_d <= ptr_d + UM;
          cont  <= cont - UM;
        end
        PREENCHE: begin
          ptr_d <= ptr_d + UM;
          cont  <= cont - UM;
        end
        default: ;
      endcase
    end
  end

  // Next-state and output decode. The memory port is driven only from state
  // and registers; the single exception is the write data in ESCREVE, which
  // forwards the byte the memory returns for the address presented in LE.
  // A transfer ends when the counter is about to step from 1 to 0.
  always_comb begin
    prox_estado     = estado;
    ocupado         = 1'b1;
    concluido       = 1'b0;
    mem_writeEnable = 1'b0;
    mem_endereco    = '0;
    mem_dadoEntrada = '0;

    case (estado)
      OCIOSO: begin
        ocupado = 1'b0;
        if (inicio) begin
          if (tamanho == '0) begin
            prox_estado = FIM;
          end else if (modo) begin
            prox_estado = PREENCHE;
          end else begin
            prox_estado = LE;
          end
        end
      end
      LE: begin
        mem_endereco = ptr_o;
        prox_estado  = ESCREVE;
      end
      ESCREVE: begin
        mem_endereco    = ptr_d;
        mem_writeEnable = 1'b1;
        mem_dadoEntrada = mem_dadoSaida;
        prox_estado     = (cont == UM) ? FIM : LE;
      end
      PREENCHE: begin
        mem_endereco    = ptr_d;
        mem_writeEnable = 1'b1;
        mem_dadoEntrada = reg_valor;
        prox_estado     = (cont == UM) ? FIM : PREENCHE;
      end
      FIM: begin
        concluido   = 1'b1;
        prox_estado = OCIOSO;
      end
      default: begin
        prox_estado = OCIOSO;
      end
    endcase
  end

endmodule

// File: tb/tb_controlador_copia_memoria.sv
// Testbench for controlador_copia_memoria: a 256x8 synchronous memory model
// is attached to the controller, and a byte-array reference model predicts
// memory contents and completion latency for every transfer.

module tb_controlador_copia_memoria;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inicio = 1'b0;
  logic       modo = 1'b0;
  logic [7:0] origem = '0;
  logic [7:0] destino = '0;
  logic [7:0] tamanho = '0;
  logic [7:0] valor = '0;
  logic       ocupado;
  logic       concluido;
  logic       mem_writeEnable;
  logic [7:0] mem_endereco;
  logic [7:0] mem_dadoEntrada;
  logic [7:0] mem_dadoSaida;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic       tb_wr = 1'b0;
  logic [7:0] tb_wa = '0;
  logic [7:0] tb_wd = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_count = 0;
  int viol = 0;

  always #5 clk = ~clk;

  controlador_copia_memoria #(.LARG_END(8), .LARG_DADO(8)) dut (
    .clk(clk),
    .rst(rst),
    .inicio(inicio),
    .modo(modo),
    .origem(origem),
    .destino(destino),
    .tamanho(tamanho),
    .valor(valor),
    .ocupado(ocupado),
    .concluido(concluido),
    .mem_writeEnable(mem_writeEnable),
    .mem_endereco(mem_endereco),
    .mem_dadoEntrada(mem_dadoEntrada),
    .mem_dadoSaida(mem_dadoSaida)
  );

  // Synchronous memory with a side port the bench uses for preloading.
  always @(posedge clk) begin
    if (tb_wr) begin
      mem[tb_wa] <= tb_wd;
    end else if (mem_writeEnable === 1'b1) begin
      mem[mem_endereco] <= mem_dadoEntrada;
    end
    mem_dadoSaida <= mem[mem_endereco];
  end

  // Count writes, and writes seen while idle or in the completion cycle.
  always @(posedge clk) begin
    if (mem_writeEnable === 1'b1) begin
      wr_count <= wr_count + 1;
      if (ocupado !== 1'b1 || concluido === 1'b1) viol <= viol + 1;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: byte-sequential forward transfer with 8-bit wrap.
  function automatic void model_op(input bit m, input logic [7:0] o,
                                   input logic [7:0] d, input int n,
                                   input logic [7:0] v);
    logic [7:0] s;
    logic [7:0] t;
    for (int i = 0; i < n; i++) begin
      s = o + 8'(i);
      t = d + 8'(i);
      ref_mem[t] = m ? v : ref_mem[s];
    end
  endfunction

  function automatic int exp_lat(input bit m, input int n);
    if (n == 0) return 1;
    return m ? n + 1 : 2 * n + 1;
  endfunction

  function automatic int first_diff();
    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== ref_mem[i]) return i;
    end
    return -1;
  endfunction

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_wr = 1'b1;
    tb_wa = a;
    tb_wd = d;
    @(negedge clk);
    tb_wr = 1'b0;
    ref_mem[a] = d;
  endtask

  // Issues one request and observes it; lat is the cycle (counted from the
  // accepting edge) in which concluido is seen, or -1 on timeout.
  task automatic run_op(input bit m, input logic [7:0] o, input logic [7:0] d,
                        input logic [7:0] t, input logic [7:0] v,
                        output int lat, output bit busy_ok, output bit idle_after);
    @(negedge clk);
    modo = m; origem = o; destino = d; tamanho = t; valor = v; inicio = 1'b1;
    lat = -1;
    busy_ok = 1'b1;
    for (int c = 1; c <= 600 && lat < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        inicio = 1'b0;
        modo = 1'($urandom);
        origem = 8'($urandom);
        destino = 8'($urandom);
        tamanho = 8'($urandom);
        valor = 8'($urandom);
      end
      if (ocupado !== 1'b1) busy_ok = 1'b0;
      if (concluido === 1'b1) lat = c;
    end
    @(negedge clk);
    idle_after = (ocupado === 1'b0) && (concluido === 1'b0);
  endtask

  task automatic test_reset();
    int w0;
    bit busy_seen;
    @(negedge clk);
    n_cmp++;
    if ({ocupado, concluido, mem_writeEnable} !== 3'b000) begin
      n_bad++;
      $display("[TB] FAIL reset_flags: got %b expected 000", {ocupado, concluido, mem_writeEnable});
    end
    n_cmp++;
    if ({mem_endereco, mem_dadoEntrada} !== 16'h0000) begin
      n_bad++;
      $display("[TB] FAIL reset_bus: got %h expected 0000", {mem_endereco, mem_dadoEntrada});
    end
    rst = 1'b0;
    w0 = wr_count;
    busy_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      origem = 8'($urandom); destino = 8'($urandom);
      tamanho = 8'($urandom); modo = 1'($urandom);
      if (ocupado !== 1'b0) busy_seen = 1'b1;
    end
    n_cmp++;
    if (wr_count != w0 || busy_seen) begin
      n_bad++;
      $display("[TB] FAIL idle_quiet: writes %0d busy %0d expected 0 0", wr_count - w0, busy_seen);
    end
  endtask

  task automatic test_init_mem();
    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
  endtask

  task automatic test_copy();
    logic [7:0] pat [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    int lat, w0;
    bit bok, iok;
    for (int i = 0; i < 4; i++) poke(8'h10 + 8'(i), pat[i]);
    w0 = wr_count;
    run_op(1'b0, 8'h10, 8'h80, 8'd4, 8'h00, lat, bok, iok);
    model_op(1'b0, 8'h10, 8'h80, 4, 8'h00);
    n_cmp++;
    if (lat != 9) begin
      n_bad++;
      $display("[TB] FAIL copy_latency: got %0d expected 9", lat);
    end
    n_cmp++;
    if (!bok || !iok) begin
      n_bad++;
      $display("[TB] FAIL copy_ocupado: busy_ok %0d idle_after %0d expected 1 1", bok, iok);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (mem[8'h80 + 8'(i)] !== pat[i]) begin
        n_bad++;
        $display("[TB] FAIL copy_byte%0d: got %h expected %h", i, mem[8'h80 + 8'(i)], pat[i]);
      end
    end
    n_cmp++;
    if (wr_count - w0 != 4 || first_diff() != -1) begin
      n_bad++;
      $display("[TB] FAIL copy_side_effects: writes %0d diff_at %0d expected 4 -1", wr_count - w0, first_diff());
    end
  endtask

  task automatic test_fill_wrap();
    logic [7:0] keep;
    int lat;
    bit bok, iok;
    keep = ref_mem[8'h01];
    run_op(1'b1, 8'h00, 8'hFE, 8'd3, 8'h5A, lat, bok, iok);
    model_op(1'b1, 8'h00, 8'hFE, 3, 8'h5A);
    n_cmp++;
    if (lat != 4) begin
      n_bad++;
      $display("[TB] FAIL fill_latency: got %0d expected 4", lat);
    end
    n_cmp++;
    if ({mem[8'hFE], mem[8'hFF], mem[8'h00]} !== 24'h5A5A5A) begin
      n_bad++;
      $display("[TB] FAIL fill_wrap_bytes: got %h%h%h expected 5a5a5a", mem[8'hFE], mem[8'hFF], mem[8'h00]);
    end
    n_cmp++;
    if (mem[8'h01] !== keep) begin
      n_bad++;
      $display("[TB] FAIL fill_no_overrun: got %h expected %h", mem[8'h01], keep);
    end
  endtask

  task automatic test_zero_length();
    int lat, w0;
    bit bok, iok;
    w0 = wr_count;
    run_op(1'b0, 8'h33, 8'h44, 8'd0, 8'h99, lat, bok, iok);
    n_cmp++;
    if (lat != 1 || !iok) begin
      n_bad++;
      $display("[TB] FAIL zero_latency: got %0d idle %0d expected 1 1", lat, iok);
    end
    n_cmp++;
    if (wr_count != w0 || first_diff() != -1) begin
      n_bad++;
      $display("[TB] FAIL zero_no_write: writes %0d diff_at %0d expected 0 -1", wr_count - w0, first_diff());
    end
  endtask

  task automatic test_busy_start();
    int lat, w0;
    bit stay_idle;
    w0 = wr_count;
    @(negedge clk);
    modo = 1'b0; origem = 8'h40; destino = 8'h90; tamanho = 8'd4; inicio = 1'b1;
    lat = -1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      inicio = (c == 3);
      if (c == 3) begin
        modo = 1'b1; origem = 8'h00; destino = 8'h08; tamanho = 8'd2; valor = 8'hEE;
      end
      if (concluido === 1'b1) lat = c;
    end
    inicio = 1'b0;
    stay_idle = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ocupado !== 1'b0) stay_idle = 1'b0;
    end
    model_op(1'b0, 8'h40, 8'h90, 4, 8'h00);
    n_cmp++;
    if (lat != 9 || !stay_idle) begin
      n_bad++;
      $display("[TB] FAIL busy_start_latency: got %0d idle %0d expected 9 1", lat, stay_idle);
    end
    n_cmp++;
    if (wr_count - w0 != 4 || first_diff() != -1) begin
      n_bad++;
      $display("[TB] FAIL busy_start_ignored: writes %0d diff_at %0d expected 4 -1", wr_count - w0, first_diff());
    end
  endtask

  task automatic test_overlap();
    int lat;
    bit bok, iok;
    poke(8'h20, 8'h11);
    poke(8'h21, 8'h22);
    poke(8'h22, 8'h33);
    run_op(1'b0, 8'h20, 8'h21, 8'd2, 8'h00, lat, bok, iok);
    model_op(1'b0, 8'h20, 8'h21, 2, 8'h00);
    n_cmp++;
    if ({mem[8'h20], mem[8'h21], mem[8'h22]} !== 24'h111111 || lat != 5) begin
      n_bad++;
      $display("[TB] FAIL overlap_smear: got %h%h%h lat %0d expected 111111 lat 5", mem[8'h20], mem[8'h21], mem[8'h22], lat);
    end
  endtask

  task automatic test_reset_mid_copy();
    int w0, pulses, lat;
    bit bok, iok;
    w0 = wr_count;
    pulses = 0;
    @(negedge clk);
    modo = 1'b0; origem = 8'h30; destino = 8'hA0; tamanho = 8'd4; inicio = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      inicio = 1'b0;
      if (concluido === 1'b1) pulses++;
    end
    n_cmp++;
    if (mem_writeEnable !== 1'b1 || mem_endereco !== 8'hA2) begin
      n_bad++;
      $display("[TB] FAIL mid_copy_write_phase: we %b addr %h expected 1 a2", mem_writeEnable, mem_endereco);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({ocupado, concluido, mem_writeEnable, mem_endereco, mem_dadoEntrada} !== 19'd0) begin
      n_bad++;
      $display("[TB] FAIL async_reset_outputs: got %b %b %b %h %h expected all 0",
               ocupado, concluido, mem_writeEnable, mem_endereco, mem_dadoEntrada);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (concluido === 1'b1) pulses++;
    end
    model_op(1'b0, 8'h30, 8'hA0, 2, 8'h00);
    n_cmp++;
    if (pulses != 0 || wr_count - w0 != 2 || first_diff() != -1) begin
      n_bad++;
      $display("[TB] FAIL mid_copy_abort: pulses %0d writes %0d diff_at %0d expected 0 2 -1",
               pulses, wr_count - w0, first_diff());
    end
    run_op(1'b0, 8'h30, 8'hA0, 8'd4, 8'h00, lat, bok, iok);
    model_op(1'b0, 8'h30, 8'hA0, 4, 8'h00);
    n_cmp++;
    if (lat != 9 || first_diff() != -1) begin
      n_bad++;
      $display("[TB] FAIL restart_after_reset: lat %0d diff_at %0d expected 9 -1", lat, first_diff());
    end
  endtask

  task automatic test_random_ops();
    bit m, bok, iok;
    logic [7:0] o, d, v;
    int n, lat, w0;
    for (int k = 0; k < 16; k++) begin
      m = 1'($urandom);
      o = 8'($urandom);
      d = 8'($urandom);
      v = 8'($urandom);
      n = int'($urandom_range(0, 9));
      w0 = wr_count;
      run_op(m, o, d, 8'(n), v, lat, bok, iok);
      model_op(m, o, d, n, v);
      n_cmp++;
      if (lat != exp_lat(m, n) || !bok || !iok) begin
        n_bad++;
        $display("[TB] FAIL random_timing%0d: lat %0d busy %0d idle %0d expected %0d 1 1",
                 k, lat, bok, iok, exp_lat(m, n));
      end
      n_cmp++;
      if (first_diff() != -1 || wr_count - w0 != n) begin
        n_bad++;
        $display("[TB] FAIL random_memory%0d: diff_at %0d writes %0d expected -1 %0d",
                 k, first_diff(), wr_count - w0, n);
      end
    end
    n_cmp++;
    if (viol != 0) begin
      n_bad++;
      $display("[TB] FAIL write_outside_transfer: got %0d expected 0", viol);
    end
  endtask

  initial begin
    $display("[TB] starting controlador_copia_memoria bench");
    test_reset();
    test_init_mem();
    test_copy();
    test_fill_wrap();
    test_zero_length();
    test_busy_start();
    test_overlap();
    test_reset_mid_copy();
    test_random_ops();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
